// File: rtl/id_frame_tx.sv
// Repeating 5-byte identity frame transmitter (header, station, rack/slot, status, xor checksum).
// UART-style 8N1 bytes on an idle-high line, with an idle gap between frames.
module id_frame_tx #(
  parameter logic [15:0] BIT_DIV  = 16'd50,
  parameter logic [7:0]  GAP_BITS = 8'd20,
  parameter logic [7:0]  HEADER   = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] i_station_id,
  input  logic [2:0] i_rack_id,
  input  logic [3:0] i_slot_id,
  input  logic       i_id_done,
  input  logic       i_id_error,
  input  logic       i_tx_en,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_frame_done,
  output logic [7:0] o_frame_cnt
);

  // state | meaning
  // IDLE  | line high, waiting for i_tx_en
  // START | start bit (0) of the current byte
  // DATA  | 8 data bits, LSB first
  // STOP  | stop bit (1); after byte 4 the frame is complete
  // GAP   | idle-high spacing of GAP_BITS bit periods before the next frame
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_GAP} state_t;

  state_t      state, state_d;
  logic [15:0] bit_tmr, bit_tmr_d;
  logic [7:0]  gap_cnt, gap_cnt_d;
  logic [2:0]  byte_idx, byte_idx_d;
  logic [2:0]  bit_idx, bit_idx_d, bit_idx_nxt;
  logic [6:0]  snap_station, snap_station_d;
  logic [2:0]  snap_rack, snap_rack_d;
  logic [3:0]  snap_slot, snap_slot_d;
  logic        snap_done, snap_done_d;
  logic        snap_err, snap_err_d;
  logic        tx_d, busy_d, frame_done_d;
  logic [7:0]  frame_cnt_d;
  logic [7:0]  b1, b2, b3, b4, cur_byte;
  logic        bit_end;

  assign b1          = {1'b0, snap_station};
  assign b2          = {1'b0, snap_rack, snap_slot};
  assign b3          = {6'b0, snap_err, snap_done};
  assign b4          = b1 ^ b2 ^ b3;
  assign bit_end     = (bit_tmr == BIT_DIV - 16'd1);
  assign bit_idx_nxt = bit_idx + 3'd1;

  always_comb begin
    case (byte_idx)
      3'd0:    cur_byte = HEADER;
      3'd1:    cur_byte = b1;
      3'd2:    cur_byte = b2;
      3'd3:    cur_byte = b3;
      default: cur_byte = b4;
    endcase
  end

  always_comb begin
    state_d        = state;
    bit_tmr_d      = bit_tmr;
    gap_cnt_d      = gap_cnt;
    byte_idx_d     = byte_idx;
    bit_idx_d      = bit_idx;
    snap_station_d = snap_station;
    snap_rack_d    = snap_rack;
    snap_slot_d    = snap_slot;
    snap_done_d    = snap_done;
    snap_err_d     = snap_err;
    tx_d           = o_tx;
    busy_d         = o_busy;
    frame_done_d   = 1'b0;
    frame_cnt_d    = o_frame_cnt;
    case (state)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (i_tx_en) begin
          snap_station_d = i_station_id;
          snap_rack_d    = i_rack_id;
          snap_slot_d    = i_slot_id;
          snap_done_d    = i_id_done;
          snap_err_d     = i_id_error;
          byte_idx_d     = 3'd0;
          bit_tmr_d      = 16'd0;
          busy_d         = 1'b1;
          tx_d           = 1'b0;
          state_d        = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          bit_tmr_d = 16'd0;
          bit_idx_d = 3'd0;
          tx_d      = cur_byte[0];
          state_d   = S_DATA;
        end else begin
          bit_tmr_d = bit_tmr + 16'd1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          bit_tmr_d = 16'd0;
          if (bit_idx == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_nxt;
            tx_d      = cur_byte[bit_idx_nxt];
          end
        end else begin
          bit_tmr_d = bit_tmr + 16'd1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          bit_tmr_d = 16'd0;
          if (byte_idx == 3'd4) begin
            gap_cnt_d    = 8'd0;
            frame_done_d = 1'b1;
            frame_cnt_d  = o_frame_cnt + 8'd1;
            tx_d         = 1'b1;
            state_d      = S_GAP;
          end else begin
            byte_idx_d = byte_idx + 3'd1;
            tx_d       = 1'b0;
            state_d    = S_START;
          end
        end else begin
          bit_tmr_d = bit_tmr + 16'd1;
        end
      end
      S_GAP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          bit_tmr_d = 16'd0;
          if (gap_cnt == GAP_BITS - 8'd1) begin
            gap_cnt_d = 8'd0;
            busy_d    = 1'b0;
            state_d   = S_IDLE;
          end else begin
            gap_cnt_d = gap_cnt + 8'd1;
          end
        end else begin
          bit_tmr_d = bit_tmr + 16'd1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Every output is registered, so reset drives the line high without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      bit_tmr      <= 16'd0;
      gap_cnt      <= 8'd0;
      byte_idx     <= 3'd0;
      bit_idx      <= 3'd0;
      snap_station <= 7'd0;
      snap_rack    <= 3'd0;
      snap_slot    <= 4'd0;
      snap_done    <= 1'b0;
      snap_err     <= 1'b0;
      o_tx         <= 1'b1;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_cnt  <= 8'd0;
    end else begin
      state        <= state_d;
      bit_tmr      <= bit_tmr_d;
      gap_cnt      <= gap_cnt_d;
      byte_idx     <= byte_idx_d;
      bit_idx      <= bit_idx_d;
      snap_station <= snap_station_d;
      snap_rack    <= snap_rack_d;
      snap_slot    <= snap_slot_d;
      snap_done    <= snap_done_d;
      snap_err     <= snap_err_d;
      o_tx         <= tx_d;
      o_busy       <= busy_d;
      o_frame_done <= frame_done_d;
      o_frame_cnt  <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_id_frame_tx.sv
// Self-checking bench for id_frame_tx: decodes the serial line and compares against a frame model.
module tb_id_frame_tx;
  localparam int BDI = 4;
  localparam logic [15:0] BD = 16'd4;
  localparam logic [7:0]  GB = 8'd20;

  logic       clk, rst_n;
  logic [6:0] station;
  logic [2:0] rack;
  logic [3:0] slot;
  logic       id_done, id_err, tx_en;
  logic       o_tx, o_busy, o_frame_done;
  logic [7:0] o_frame_cnt;

  int total = 0;
  int bad = 0;
  int exp_cnt = 0;
  int cyc = 0;

  id_frame_tx #(.BIT_DIV(BD), .GAP_BITS(GB), .HEADER(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_station_id(station), .i_rack_id(rack), .i_slot_id(slot),
    .i_id_done(id_done), .i_id_error(id_err), .i_tx_en(tx_en),
    .o_tx(o_tx), .o_busy(o_busy), .o_frame_done(o_frame_done), .o_frame_cnt(o_frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame model: byte i sits at bits [8i+7:8i].
  function automatic logic [39:0] model_frame(input logic [6:0] st, input logic [2:0] rk,
                                              input logic [3:0] sl, input logic dn, input logic er);
    int v1, v2, v3, v4;
    v1 = int'(st);
    v2 = int'(rk) * 16 + int'(sl);
    v3 = int'(er) * 2 + int'(dn);
    v4 = v1 ^ v2 ^ v3;
    return {8'(v4), 8'(v3), 8'(v2), 8'(v1), 8'hA5};
  endfunction

  // Waits for a start bit, then decodes 50 bit periods sampling every clock.
  task automatic capture(input int slot_chg_at, input logic [3:0] new_slot, input int en_drop_at,
                         output logic found, output logic [39:0] got, output logic timing_ok,
                         output logic framing_ok, output int done_lat, output logic pulse_ok,
                         output int cnt_at_done, output int fall_at);
    logic bitv;
    int pos;
    found = 1'b0; got = '0; timing_ok = 1'b1; framing_ok = 1'b1;
    done_lat = -1; pulse_ok = 1'b0; cnt_at_done = -1; fall_at = -1; bitv = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (o_tx === 1'b0) begin found = 1'b1; break; end
    end
    if (!found) return;
    fall_at = cyc;
    for (int s = 0; s < 50 * BDI; s++) begin
      if (s > 0) @(negedge clk);
      if (s == slot_chg_at) slot = new_slot;
      if (s == en_drop_at) tx_en = 1'b0;
      if (done_lat < 0 && o_frame_done === 1'b1) done_lat = s;
      if (s % BDI == 0) begin
        bitv = o_tx;
        pos = (s / BDI) % 10;
        if (pos == 0 && bitv !== 1'b0) framing_ok = 1'b0;
        else if (pos == 9 && bitv !== 1'b1) framing_ok = 1'b0;
        else if (pos != 0 && pos != 9) got[(s / BDI / 10) * 8 + pos - 1] = bitv;
      end else if (o_tx !== bitv) begin
        timing_ok = 1'b0;
      end
    end
    if (done_lat < 0) begin
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (o_frame_done === 1'b1) begin done_lat = 50 * BDI + i; break; end
      end
    end
    if (done_lat >= 0) begin
      cnt_at_done = int'(o_frame_cnt);
      @(negedge clk);
      pulse_ok = (o_frame_done === 1'b0);
    end
  endtask

  task automatic idle_wait(output int lat);
    lat = -1;
    for (int i = 0; i < 1000; i++) begin
      if (o_busy === 1'b0) begin lat = i; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    #12;
    total++; if (o_tx !== 1'b1) begin bad++; $display("FAIL rst_tx got=%b exp=1", o_tx); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", o_busy); end
    total++; if (o_frame_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", o_frame_done); end
    total++; if (o_frame_cnt !== 8'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", o_frame_cnt); end
    @(negedge clk); rst_n = 1'b1;
    repeat (20) @(negedge clk);
    total++; if (o_tx !== 1'b1 || o_busy !== 1'b0) begin
      bad++; $display("FAIL idle_no_en got tx=%b busy=%b exp tx=1 busy=0", o_tx, o_busy);
    end
  endtask

  task automatic run_frame(input string name, input logic [39:0] expf);
    logic found, tok, fok, pok; logic [39:0] got; int dl, cad, fa, lat;
    tx_en = 1'b1;
    capture(-1, 4'h0, -1, found, got, tok, fok, dl, pok, cad, fa);
    tx_en = 1'b0;
    exp_cnt = (exp_cnt + 1) % 256;
    total++; if (!found) begin bad++; $display("FAIL %s_start got=none exp=start bit", name); end
    total++; if (got !== expf) begin bad++; $display("FAIL %s_bytes got=%h exp=%h", name, got, expf); end
    total++; if (!tok || !fok) begin bad++; $display("FAIL %s_bits got timing=%b framing=%b exp 1 1", name, tok, fok); end
    total++; if (dl != 200) begin bad++; $display("FAIL %s_done_lat got=%0d exp=200", name, dl); end
    total++; if (!pok) begin bad++; $display("FAIL %s_done_width got=not 1 clk exp=1 clk", name); end
    total++; if (cad != exp_cnt) begin bad++; $display("FAIL %s_cnt got=%0d exp=%0d", name, cad, exp_cnt); end
    idle_wait(lat);
    total++; if (lat < 0) begin bad++; $display("FAIL %s_idle got=busy exp=idle", name); end
  endtask

  task automatic test_nominal;
    station = 7'h15; rack = 3'h5; slot = 4'hA; id_done = 1'b1; id_err = 1'b0;
    total++; if (model_frame(station, rack, slot, id_done, id_err) !== 40'h4E_01_5A_15_A5) begin
      bad++; $display("FAIL nominal_model got=%h exp=4e015a15a5", model_frame(station, rack, slot, id_done, id_err));
    end
    run_frame("nominal", 40'h4E_01_5A_15_A5);
  endtask

  task automatic test_error_status;
    station = 7'h00; rack = 3'h0; slot = 4'h0; id_done = 1'b0; id_err = 1'b1;
    run_frame("error", model_frame(station, rack, slot, id_done, id_err));
  endtask

  task automatic test_random;
    for (int n = 0; n < 3; n++) begin
      station = 7'($urandom); rack = 3'($urandom); slot = 4'($urandom);
      id_done = 1'($urandom); id_err = 1'($urandom);
      run_frame("random", model_frame(station, rack, slot, id_done, id_err));
    end
  endtask

  task automatic test_snapshot;
    logic found, tok, fok, pok; logic [39:0] got1, got2, e1, e2; int dl, cad, fa, lat;
    station = 7'h15; rack = 3'h5; slot = 4'hA; id_done = 1'b1; id_err = 1'b0;
    e1 = model_frame(station, rack, slot, id_done, id_err);
    e2 = model_frame(station, rack, 4'h3, id_done, id_err);
    tx_en = 1'b1;
    capture(12 * BDI + 1, 4'h3, -1, found, got1, tok, fok, dl, pok, cad, fa);
    capture(-1, 4'h0, -1, found, got2, tok, fok, dl, pok, cad, fa);
    tx_en = 1'b0;
    exp_cnt = (exp_cnt + 2) % 256;
    total++; if (got1 !== e1) begin bad++; $display("FAIL snap_first got=%h exp=%h", got1, e1); end
    total++; if (got2 !== e2) begin bad++; $display("FAIL snap_second got=%h exp=%h", got2, e2); end
    total++; if (got2[23:16] !== 8'h53) begin bad++; $display("FAIL snap_b2 got=%h exp=53", got2[23:16]); end
    total++; if (cad != exp_cnt) begin bad++; $display("FAIL snap_cnt got=%0d exp=%0d", cad, exp_cnt); end
    idle_wait(lat);
  endtask

  task automatic test_enable_drop;
    logic found, tok, fok, pok, quiet; logic [39:0] got, expf; int dl, cad, fa, lat;
    station = 7'($urandom); rack = 3'($urandom); slot = 4'($urandom); id_done = 1'b1; id_err = 1'b0;
    expf = model_frame(station, rack, slot, id_done, id_err);
    tx_en = 1'b1;
    capture(-1, 4'h0, 24 * BDI + 2, found, got, tok, fok, dl, pok, cad, fa);
    exp_cnt = (exp_cnt + 1) % 256;
    total++; if (got !== expf) begin bad++; $display("FAIL drop_bytes got=%h exp=%h", got, expf); end
    total++; if (dl != 200) begin bad++; $display("FAIL drop_done_lat got=%0d exp=200", dl); end
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL drop_busy_gap got=%b exp=1", o_busy); end
    idle_wait(lat);
    total++; if (lat != 79) begin bad++; $display("FAIL drop_busy_fall got=%0d exp=79", lat); end
    quiet = 1'b1;
    repeat (300) begin
      @(negedge clk);
      if (o_tx !== 1'b1 || o_busy !== 1'b0) quiet = 1'b0;
    end
    total++; if (!quiet) begin bad++; $display("FAIL drop_no_restart got=activity exp=idle"); end
  endtask

  task automatic test_continuous;
    logic found, tok, fok, pok, seen; logic [39:0] got, expf; int dl, cad, fa1, fa2, lat;
    station = 7'($urandom); rack = 3'($urandom); slot = 4'($urandom); id_done = 1'b1; id_err = 1'b0;
    expf = model_frame(station, rack, slot, id_done, id_err);
    tx_en = 1'b1;
    capture(-1, 4'h0, -1, found, got, tok, fok, dl, pok, cad, fa1);
    capture(-1, 4'h0, -1, found, got, tok, fok, dl, pok, cad, fa2);
    exp_cnt = (exp_cnt + 2) % 256;
    total++; if (fa2 - fa1 != 281) begin bad++; $display("FAIL cont_spacing got=%0d exp=281", fa2 - fa1); end
    total++; if (got !== expf) begin bad++; $display("FAIL cont_bytes got=%h exp=%h", got, expf); end
    total++; if (cad != exp_cnt) begin bad++; $display("FAIL cont_cnt got=%0d exp=%0d", cad, exp_cnt); end
    for (int f = 0; f < 260; f++) begin
      seen = 1'b0;
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        if (o_frame_done === 1'b1) begin seen = 1'b1; break; end
      end
      if (!seen) begin total++; bad++; $display("FAIL wrap_timeout got=no done exp=done"); break; end
      exp_cnt = (exp_cnt + 1) % 256;
      total++; if (int'(o_frame_cnt) != exp_cnt) begin
        bad++; $display("FAIL wrap_cnt got=%0d exp=%0d", o_frame_cnt, exp_cnt);
      end
      if (exp_cnt == 0) break;
    end
    tx_en = 1'b0;
    idle_wait(lat);
  endtask

  task automatic test_reset_mid;
    logic found, tok, fok, pok; logic [39:0] got, expf; int dl, cad, fa;
    station = 7'h15; rack = 3'h5; slot = 4'hA; id_done = 1'b1; id_err = 1'b0;
    expf = model_frame(station, rack, slot, id_done, id_err);
    tx_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (o_tx === 1'b0) begin found = 1'b1; break; end
    end
    repeat (30 * BDI) @(negedge clk);
    total++; if (!found || o_tx !== 1'b0) begin bad++; $display("FAIL mid_pre_tx got=%b exp=0", o_tx); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (o_tx !== 1'b1) begin bad++; $display("FAIL mid_rst_tx got=%b exp=1", o_tx); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b exp=0", o_busy); end
    total++; if (o_frame_cnt !== 8'd0) begin bad++; $display("FAIL mid_rst_cnt got=%0d exp=0", o_frame_cnt); end
    @(negedge clk); rst_n = 1'b1;
    exp_cnt = 0;
    capture(-1, 4'h0, -1, found, got, tok, fok, dl, pok, cad, fa);
    tx_en = 1'b0;
    exp_cnt = 1;
    total++; if (got[7:0] !== 8'hA5) begin bad++; $display("FAIL mid_header got=%h exp=a5", got[7:0]); end
    total++; if (got !== expf) begin bad++; $display("FAIL mid_bytes got=%h exp=%h", got, expf); end
    total++; if (dl != 200) begin bad++; $display("FAIL mid_done_lat got=%0d exp=200", dl); end
    total++; if (cad != exp_cnt) begin bad++; $display("FAIL mid_cnt got=%0d exp=%0d", cad, exp_cnt); end
  endtask

  initial begin
    rst_n = 1'b0; tx_en = 1'b0;
    station = '0; rack = '0; slot = '0; id_done = 1'b0; id_err = 1'b0;
    test_reset();
    test_nominal();
    test_error_status();
    test_snapshot();
    test_random();
    test_enable_drop();
    test_continuous();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
